// File: rtl/des_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : des_round_ctrl
// Purpose  : Round sequencer and C/D key-schedule generator for an iterative
//            DES core (one Feistel round per clock, encrypt or decrypt order).
// Revision : 1.0 - initial release
// ============================================================================
module des_round_ctrl #(
    parameter logic [15:0] SHIFT_MAP = 16'h8103
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [55:0] key_cd,
    input  logic        stall,
    output logic        busy,
    output logic        ld_data,
    output logic        round_en,
    output logic [3:0]  round,
    output logic [27:0] key_c,
    output logic [27:0] key_d,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_FINAL = 2'd3
    } state_t;

    localparam logic [3:0] c_last_round = 4'd15;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_dir;
    logic        w_dir_nxt;
    logic [3:0]  r_round;
    logic [3:0]  w_round_nxt;
    logic [3:0]  w_round_inc;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [27:0] w_c_nxt;
    logic [27:0] w_d_nxt;
    logic        w_single;

    // Left/right rotation of a 28-bit half by one or two positions.
    function automatic logic [27:0] rot_l(input logic [27:0] x, input logic one);
        rot_l = one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rot_r(input logic [27:0] x, input logic one);
        rot_r = one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    assign w_round_inc = r_round + 4'd1;

    // Decrypt walks the schedule backwards, so it looks up round 16-(r+1).
    assign w_single = r_dir ? SHIFT_MAP[c_last_round - r_round]
                            : SHIFT_MAP[w_round_inc];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir   <= 1'b0;
            r_round <= 4'd0;
            r_c     <= 28'd0;
            r_d     <= 28'd0;
        end else begin
            r_dir   <= w_dir_nxt;
            r_round <= w_round_nxt;
            r_c     <= w_c_nxt;
            r_d     <= w_d_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_round_nxt = r_round;
        w_c_nxt     = r_c;
        w_d_nxt     = r_d;
        busy        = 1'b0;
        ld_data     = 1'b0;
        round_en    = 1'b0;
        done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_dir_nxt   = decrypt;
                    w_c_nxt     = key_cd[55:28];
                    w_d_nxt     = key_cd[27:0];
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                busy        = 1'b1;
                ld_data     = 1'b1;
                w_round_nxt = 4'd0;
                // Decrypt round 0 uses the full 28-bit rotation, i.e. C0/D0 itself.
                if (!r_dir) begin
                    w_c_nxt = rot_l(r_c, 1'b1);
                    w_d_nxt = rot_l(r_d, 1'b1);
                end
                w_state_nxt = S_ROUND;
            end
            S_ROUND: begin
                busy = 1'b1;
                // round_en must track the same-cycle stall so the datapath
                // and the sequencer always advance together.
                if (!stall) begin
                    round_en = 1'b1;
                    if (r_round == c_last_round) begin
                        w_state_nxt = S_FINAL;
                    end else begin
                        w_round_nxt = w_round_inc;
                        if (r_dir) begin
                            w_c_nxt = rot_r(r_c, w_single);
                            w_d_nxt = rot_r(r_d, w_single);
                        end else begin
                            w_c_nxt = rot_l(r_c, w_single);
                            w_d_nxt = rot_l(r_d, w_single);
                        end
                    end
                end
            end
            S_FINAL: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign round = r_round;
    assign key_c = r_c;
    assign key_d = r_d;

endmodule
`default_nettype wire

// File: tb/tb_des_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_round_ctrl
// Purpose  : Directed and randomised self-checking bench for des_round_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_round_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic [55:0] key_cd = '0;
    logic        stall = 1'b0;
    logic        busy;
    logic        ld_data;
    logic        round_en;
    logic [3:0]  round;
    logic [27:0] key_c;
    logic [27:0] key_d;
    logic        done;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [27:0] cap_c [16];
    logic [27:0] cap_d [16];
    int          c_shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_round_ctrl #(.SHIFT_MAP(16'h8103)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .decrypt  (decrypt),
        .key_cd   (key_cd),
        .stall    (stall),
        .busy     (busy),
        .ld_data  (ld_data),
        .round_en (round_en),
        .round    (round),
        .key_c    (key_c),
        .key_d    (key_d),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int cum(input int k);
        int s = 0;
        for (int i = 0; i <= k; i++) s += c_shifts[i];
        return s;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
        return (x << n) | (x >> (28 - n));
    endfunction

    // Encrypt round k holds the cumulative left rotation; decrypt round r equals encrypt round 15-r.
    function automatic logic [27:0] exp_half(input logic [27:0] h0, input logic dir, input int r);
        return rotl(h0, cum(dir ? 15 - r : r));
    endfunction

    task automatic run(input logic [55:0] key, input logic dir, input int st_at,
                       input int st_len, input logic noise);
        int cyc, ph, mr, scnt, n_ld, n_en, n_dn, dcyc;
        logic [27:0] c0, d0;
        c0 = key[55:28];
        d0 = key[27:0];
        cyc = 0; ph = 1; mr = 0; scnt = 0; n_ld = 0; n_en = 0; n_dn = 0; dcyc = 0;
        start = 1'b1; decrypt = dir; key_cd = key;
        while (ph != 0 && cyc < 60) begin
            tick();
            cyc++;
            start   = noise && (cyc == 5 || cyc == 18);
            key_cd  = ~key;
            decrypt = ~dir;
            stall   = (ph == 2 && mr == st_at && scnt < st_len) || (noise && ph != 2);
            #1;
            chk("busy", busy, 1'b1);
            chk("ld_data", ld_data, ph == 1);
            chk("round_en", round_en, ph == 2 && !stall);
            chk("done", done, ph == 3);
            n_ld += ld_data;
            n_en += round_en;
            n_dn += done;
            if (ph == 2) begin
                chk("round", round, mr);
                chk("key_c", key_c, exp_half(c0, dir, mr));
                chk("key_d", key_d, exp_half(d0, dir, mr));
                cap_c[mr] = key_c;
                cap_d[mr] = key_d;
            end
            case (ph)
                1: ph = 2;
                2: if (stall) scnt++; else if (mr == 15) ph = 3; else mr++;
                default: begin dcyc = cyc; ph = 0; end
            endcase
        end
        chk("timeout", ph, 0);
        stall = 1'b0;
        tick();
        start = 1'b0;
        chk("idle_busy", busy, 1'b0);
        chk("hold_round", round, 4'd15);
        chk("hold_key_c", key_c, exp_half(c0, dir, 15));
        chk("hold_key_d", key_d, exp_half(d0, dir, 15));
        chk("n_ld_data", n_ld, 1);
        chk("n_round_en", n_en, 16);
        chk("n_done", n_dn, 1);
        chk("done_cycle", dcyc, 18 + st_len);
    endtask

    initial begin
        logic [55:0] k0;
        k0 = {28'h0000001, 28'h8000000};

        // Reset state.
        repeat (2) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_ld_data", ld_data, 1'b0);
        chk("rst_round_en", round_en, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_round", round, 4'd0);
        chk("rst_key_c", key_c, 28'd0);
        chk("rst_key_d", key_d, 28'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_after_rst", busy, 1'b0);

        // Encrypt with hand-computed schedule.
        run(k0, 1'b0, 0, 0, 1'b0);
        chk("enc_r0_c", cap_c[0], 28'h0000002);
        chk("enc_r0_d", cap_d[0], 28'h0000001);
        chk("enc_r1_c", cap_c[1], 28'h0000004);
        chk("enc_r1_d", cap_d[1], 28'h0000002);
        chk("enc_r2_c", cap_c[2], 28'h0000010);
        chk("enc_r2_d", cap_d[2], 28'h0000008);
        chk("enc_r15_c", cap_c[15], 28'h0000001);
        chk("enc_r15_d", cap_d[15], 28'h8000000);

        // Decrypt, started back-to-back in the idle cycle after the encrypt run.
        run(k0, 1'b1, 0, 0, 1'b0);
        chk("dec_r0_c", cap_c[0], 28'h0000001);
        chk("dec_r0_d", cap_d[0], 28'h8000000);
        chk("dec_r1_c", cap_c[1], 28'h8000000);
        chk("dec_r1_d", cap_d[1], 28'h4000000);

        // Three-cycle stall at round 5.
        run({28'h0123456, 28'h789abcd}, 1'b0, 5, 3, 1'b0);

        // Start pulses with a different key/direction while busy and in FINAL.
        run({28'hfedcba9, 28'h8765432}, 1'b0, 16, 0, 1'b1);

        // Reset mid-run aborts without a done pulse.
        start = 1'b1; decrypt = 1'b0; key_cd = {28'h5a5a5a5, 28'ha5a5a5a};
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("pre_abort_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_round_en", round_en, 1'b0);
        chk("abort_round", round, 4'd0);
        chk("abort_key_c", key_c, 28'd0);
        chk("abort_key_d", key_d, 28'd0);
        repeat (2) begin
            tick();
            chk("abort_done", done, 1'b0);
            chk("abort_ld_data", ld_data, 1'b0);
        end
        #2 rst_n = 1'b1;
        tick();
        run({28'h0f0f0f0, 28'h3c3c3c3}, 1'b1, 16, 0, 1'b0);

        // Randomised keys, directions, stalls and bus noise.
        for (int i = 0; i < 200; i++) begin
            run({$urandom(), $urandom()} & 56'hff_ffff_ffff_ffff,
                1'($urandom_range(0, 1)), $urandom_range(0, 15),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
